// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS CPU: opcodes, PC source
// selects and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_JMP  = 2'b10,
    PCSRC_HOLD = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for sequential, branch and jump flow.
// PC is a word index, so the branch offset is added without scaling.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  output logic [PC_W-1:0] pc_plus1,
  output logic [PC_W-1:0] next_pc
);

  logic signed [PC_W-1:0] offset;
  logic [PC_W-1:0]        branch_target;
  logic [PC_W-1:0]        jump_target;

  assign pc_plus1      = pc + PC_W'(1);
  assign offset        = PC_W'(signed'(imm16));
  assign branch_target = pc_plus1 + $unsigned(offset);
  assign jump_target   = PC_W'(target26);

  always_comb begin
    next_pc = pc_plus1;
    case (pc_src_e'(pc_src))
      PCSRC_SEQ:  next_pc = pc_plus1;
      PCSRC_BR:   next_pc = branch_taken ? branch_target : pc_plus1;
      PCSRC_JMP:  next_pc = jump_target;
      PCSRC_HOLD: next_pc = pc;
      default:    next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, latches the IMem word into IR one cycle after a
// fetch request, and applies control-requested PC updates while holding.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  output logic [31:0]     ir,
  output logic            ir_valid,
  output logic [5:0]      opcode,
  output logic [4:0]      reg_a,
  output logic [4:0]      reg_b,
  output logic [4:0]      reg_c,
  output logic [15:0]     imm16,
  output logic [25:0]     target26,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic [PC_W-1:0] instr_count
);

  fetch_state_e    state, state_next;
  logic [PC_W-1:0] next_pc;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc           (pc),
    .imm16        (imm16),
    .target26     (target26),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .pc_plus1     (pc_plus1),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_next = state;
    ir_valid   = 1'b0;
    case (state)
      ST_IDLE:  if (fetch_start) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_HOLD;
      ST_HOLD: begin
        ir_valid = 1'b1;
        if (fetch_start) state_next = ST_FETCH;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // The PC update and the fetch request may share a HOLD edge, so the
  // following FETCH cycle already presents the updated address to IMem.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == ST_HOLD && pc_write) pc <= next_pc;
      if (state == ST_FETCH) begin
        ir          <= imem_instr;
        instr_count <= instr_count + PC_W'(1);
      end
    end
  end

  assign imem_pc  = pc;
  assign opcode   = ir[31:26];
  assign reg_a    = ir[25:21];
  assign reg_b    = ir[20:16];
  assign reg_c    = ir[15:11];
  assign imm16    = ir[15:0];
  assign target26 = ir[25:0];

endmodule
